// File: rtl/neuron_akumulator.sv
// rtl/neuron_akumulator.sv - per-neuron MAC with bias, emitting sign + saturated Q3.19 magnitude
// Optional saturation flag output enabled by defining NEURON_PREKORACENJE_EN.
module neuron_akumulator #(
  parameter int BROJ_ULAZA = 60,
  parameter int ULAZ_W     = 16,
  parameter int TEZINA_W   = 16,
  parameter int ACC_W      = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TEZINA_W-1:0] pristranost,
  input  logic                ulaz_valid,
  output logic                ulaz_ready,
  input  logic [ULAZ_W-1:0]   ulaz,
  input  logic [TEZINA_W-1:0] tezina,
  output logic [21:0]         suma,
  output logic                predznak,
  output logic                izlaz_valid,
  input  logic                izlaz_ready,
  output logic                zauzet
`ifdef NEURON_PREKORACENJE_EN
  ,
  output logic                prekoracenje
`endif
);

  localparam int CNT_W  = (BROJ_ULAZA > 1) ? $clog2(BROJ_ULAZA) : 1;
  localparam int PROD_W = ULAZ_W + TEZINA_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZADNJI = CNT_W'(BROJ_ULAZA - 1);
  localparam logic [ACC_W-1:0] MAG_MAX    = ACC_W'(22'h3FFFFF);

  typedef enum logic [1:0] {
    MIR      = 2'd0,
    AKUM     = 2'd1,
    PRETVORI = 2'd2,
    IZLAZ    = 2'd3
  } stanje_t;

  stanje_t stanje, stanje_sljedece;

  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic signed [PROD_W-1:0] proizvod;
  logic        [ACC_W-1:0]  proizvod_ext;
  logic        [ACC_W-1:0]  pristranost_ext;
  logic        [ACC_W-1:0]  apsolutno;
  logic        [ACC_W-1:0]  mag;
  logic                     zasicenje;
  logic                     prihvat;

  assign prihvat  = ulaz_valid && ulaz_ready;
  assign proizvod = $signed({1'b0, ulaz}) * $signed(tezina);
  assign proizvod_ext = {{(ACC_W-PROD_W){proizvod[PROD_W-1]}}, proizvod};
  // Bias is Q4.12; shifting by the input's 16 fraction bits aligns it to the Q.28 product.
  assign pristranost_ext = {{(ACC_W-TEZINA_W-ULAZ_W){pristranost[TEZINA_W-1]}},
                            pristranost, {ULAZ_W{1'b0}}};

  // Magnitude first, then shift: truncation is toward zero for either sign.
  assign apsolutno = acc[ACC_W-1] ? (~acc + 1'b1) : acc;
  assign mag       = apsolutno >> 9;
  assign zasicenje = (mag > MAG_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje <= MIR;
    end else begin
      stanje <= stanje_sljedece;
    end
  end

  always_comb begin
    stanje_sljedece = stanje;
    case (stanje)
      MIR:      if (start) stanje_sljedece = AKUM;
      AKUM:     if (prihvat && (cnt == CNT_ZADNJI)) stanje_sljedece = PRETVORI;
      PRETVORI: stanje_sljedece = IZLAZ;
      IZLAZ:    if (izlaz_ready) stanje_sljedece = MIR;
      default:  stanje_sljedece = MIR;
    endcase
  end

  always_comb begin
    ulaz_ready = (stanje == AKUM);
    zauzet     = (stanje != MIR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      suma        <= '0;
      predznak    <= 1'b0;
      izlaz_valid <= 1'b0;
`ifdef NEURON_PREKORACENJE_EN
      prekoracenje <= 1'b0;
`endif
    end else begin
      case (stanje)
        MIR: begin
          if (start) begin
            acc <= pristranost_ext;
            cnt <= '0;
          end
        end
        AKUM: begin
          if (prihvat) begin
            acc <= acc + proizvod_ext;
            cnt <= cnt + 1'b1;
          end
        end
        PRETVORI: begin
          suma        <= zasicenje ? 22'h3FFFFF : mag[21:0];
          // A negative sum that truncates to zero is reported as +0.
          predznak    <= acc[ACC_W-1] && (mag != '0);
          izlaz_valid <= 1'b1;
`ifdef NEURON_PREKORACENJE_EN
          prekoracenje <= zasicenje;
`endif
        end
        IZLAZ: begin
          if (izlaz_ready) izlaz_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_akumulator.sv
// tb/tb_neuron_akumulator.sv - scoreboard bench for neuron_akumulator with a high-level arithmetic model
module tb_neuron_akumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pristranost = '0;
  logic        ulaz_valid = 1'b0;
  logic        ulaz_ready;
  logic [15:0] ulaz = '0;
  logic [15:0] tezina = '0;
  logic [21:0] suma;
  logic        predznak;
  logic        izlaz_valid;
  logic        izlaz_ready = 1'b1;
  logic        zauzet;
`ifdef NEURON_PREKORACENJE_EN
  logic        prekoracenje;
`endif

  neuron_akumulator #(.BROJ_ULAZA(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pristranost(pristranost),
    .ulaz_valid(ulaz_valid), .ulaz_ready(ulaz_ready), .ulaz(ulaz), .tezina(tezina),
    .suma(suma), .predznak(predznak), .izlaz_valid(izlaz_valid),
    .izlaz_ready(izlaz_ready), .zauzet(zauzet)
`ifdef NEURON_PREKORACENJE_EN
    , .prekoracenje(prekoracenje)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncnt = 0;
  logic [23:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] u [4];
  logic [15:0] w [4];

  always @(posedge clk) ncnt <= ncnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: real-valued arithmetic on integers, packed as {sat, sign, magnitude}.
  function automatic logic [23:0] model(input logic [15:0] b);
    longint s, a, m;
    logic [21:0] mg;
    logic sat, neg;
    s = longint'($signed(b)) * 65536;
    for (int i = 0; i < 4; i++) s += longint'(u[i]) * longint'($signed(w[i]));
    a = (s < 0) ? -s : s;
    m = a / 512;
    sat = (m > 64'h3FFFFF);
    mg = sat ? 22'h3FFFFF : m[21:0];
    neg = (s < 0) && (m != 0);
    return {sat, neg, mg};
  endfunction

  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [22:0] prev_out = '0;

  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (izlaz_valid && !prev_valid) begin
        if (lat_q.size() == 0) chk("latency_unexpected", 1, 0);
        else chk("latency", ncnt, lat_q.pop_front());
      end
      if (prev_stall && izlaz_valid) chk("stall_stable", {predznak, suma}, prev_out);
      if (izlaz_valid && izlaz_ready) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("suma", suma, e[21:0]);
          chk("predznak", predznak, e[22]);
`ifdef NEURON_PREKORACENJE_EN
          chk("prekoracenje", prekoracenje, e[23]);
`endif
        end
      end
      prev_valid = izlaz_valid;
      prev_stall = izlaz_valid && !izlaz_ready;
      prev_out   = {predznak, suma};
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((zauzet || exp_q.size() != 0) && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("idle_timeout", (g < 200), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_suma"}, suma, 0);
    chk({nm, "_predznak"}, predznak, 0);
    chk({nm, "_izlaz_valid"}, izlaz_valid, 0);
    chk({nm, "_zauzet"}, zauzet, 0);
    chk({nm, "_ulaz_ready"}, ulaz_ready, 0);
`ifdef NEURON_PREKORACENJE_EN
    chk({nm, "_prekoracenje"}, prekoracenje, 0);
`endif
  endtask

  task automatic run(input logic [15:0] b, input bit bub, input int stall, input int abort_after);
    int guard = 0;
    wait_idle();
    if (abort_after == 0) exp_q.push_back(model(b));
    izlaz_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1;
    pristranost = b;
    @(posedge clk); #1;
    start = 1'b0;
    pristranost = 16'($urandom);
    for (int i = 0; i < 4;) begin
      if (bub && $urandom_range(0, 2) == 0) begin
        ulaz_valid = 1'b0;
        ulaz = 16'($urandom);
        tezina = 16'($urandom);
      end else begin
        ulaz_valid = 1'b1;
        ulaz = u[i];
        tezina = w[i];
      end
      @(negedge clk);
      if (ulaz_valid) begin
        chk("ulaz_ready_akum", ulaz_ready, 1);
        if (ulaz_ready) begin
          if (i == 3) lat_q.push_back(ncnt + 2);
          i++;
        end
      end
      guard++;
      if (guard > 100) begin
        chk("beat_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      if (abort_after != 0 && i == abort_after) begin
        ulaz_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    ulaz_valid = 1'b0;
    if (stall > 0) begin
      guard = 0;
      while (!izlaz_valid && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("valid_timeout", (guard < 20), 1);
      for (int k = 0; k < stall; k++) begin
        start = 1'b1;
        pristranost = 16'h7FFF;
        ulaz_valid = 1'b1;
        @(negedge clk);
        chk("ulaz_ready_izlaz", ulaz_ready, 0);
        chk("zauzet_izlaz", zauzet, 1);
        @(posedge clk); #1;
      end
      start = 1'b0;
      ulaz_valid = 1'b0;
      izlaz_ready = 1'b1;
      wait_idle();
      chk("start_ignored", zauzet, 0);
    end
  endtask

  task automatic set_all(input logic [15:0] uu, input logic [15:0] ww);
    for (int i = 0; i < 4; i++) begin
      u[i] = uu;
      w[i] = ww;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_all(16'h8000, 16'h1000); run(16'h0000, 0, 0, 0);
    set_all(16'h8000, 16'hF000); run(16'h0000, 0, 0, 0);
    set_all(16'h0000, 16'h1234); run(16'h0800, 0, 0, 0);
    set_all(16'hFFFF, 16'h7FFF); run(16'h0000, 0, 0, 0);
    set_all(16'h8000, 16'h1000); run(16'h0000, 1, 5, 0);
    set_all(16'h0001, 16'hFFFF); run(16'h0000, 0, 0, 0);
    set_all(16'h8000, 16'h1000); run(16'h0000, 0, 0, 2);
    set_all(16'h8000, 16'h1000); run(16'h0000, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        u[i] = 16'($urandom);
        w[i] = (r % 2 == 0) ? 16'($urandom) : 16'($signed(13'($urandom)));
      end
      run(16'($urandom), 1, (r % 3 == 0) ? int'($urandom_range(1, 4)) : 0, 0);
    end

    wait_idle();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("lat_q_empty", lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
